// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one word read at a time to instruction memory,
// queues returned words tagged with their PC, and drives the PC advance/stall.
module fetch_unit #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  input  logic            flush,
  output logic            pc_enable,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DROP
  } state_t;

  state_t          r_state;
  logic [PW:0]     r_count;
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [XLEN-1:0] r_req_pc;
  logic [XLEN-1:0] r_fifo_data [DEPTH];
  logic [XLEN-1:0] r_fifo_pc   [DEPTH];

  logic w_req_fire;
  logic w_push;
  logic w_pop;

  // A request is only offered when a FIFO slot is already reserved for its response.
  assign imem_req_valid = !reset && !flush && (r_state == S_IDLE) && (r_count != FULL);
  assign imem_req_addr  = pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;
  assign pc_enable      = !reset && (w_req_fire || flush);

  assign inst_valid = !reset && (r_count != '0);
  assign inst_data  = r_fifo_data[r_rd_ptr];
  assign inst_pc    = r_fifo_pc[r_rd_ptr];

  assign w_push = !reset && !flush && (r_state == S_WAIT) && imem_resp_valid;
  assign w_pop  = inst_valid && inst_ready && !flush;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_req_pc <= '0;
    end else if (flush) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      // An outstanding response still has to arrive; DROP swallows it.
      case (r_state)
        S_WAIT, S_DROP: r_state <= imem_resp_valid ? S_IDLE : S_DROP;
        default:        r_state <= S_IDLE;
      endcase
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req_fire) begin
            r_req_pc <= pc;
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: if (imem_resp_valid) r_state <= S_IDLE;
        S_DROP: if (imem_resp_valid) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= imem_resp_data;
      r_fifo_pc[r_wr_ptr]   <= r_req_pc;
    end
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage between program_counter and the instruction memory / decode stage.
- Consumes the PC value and issues word-address read requests to instruction memory with a valid/ready handshake.
- Buffers returned instructions, tagged with their PC, in a small FIFO for decode.
- Drives the PC enable (advance/stall). Handles redirects by flushing and squashing any in-flight response.

Parameters:
- XLEN, 32, width of PC, address and instruction.
- DEPTH, 2, instruction FIFO entries; power of two, >= 2.

Ports:
- clock  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- pc  input  XLEN  current PC (word address) from program_counter.
- flush  input  1  one-cycle redirect pulse; program_counter sel is asserted with branch target in the same cycle.
- pc_enable  output  1  to program_counter enable; PC updates on the next posedge.
- imem_req_valid  output  1  read request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  XLEN  request word address.
- imem_resp_valid  input  1  read data valid; one response per accepted request, in order, at least 1 cycle after acceptance.
- imem_resp_data  input  XLEN  instruction word.
- inst_valid  output  1  FIFO head valid to decode.
- inst_ready  input  1  decode accepts head.
- inst_data  output  XLEN  head instruction.
- inst_pc  output  XLEN  PC of head instruction.

Behaviour:
- Reset (sync, high) forces state=IDLE, FIFO count=0, read/write pointers=0, req_pc register=0.
- While reset is high: imem_req_valid=0, pc_enable=0, inst_valid=0. imem_req_addr, inst_data and inst_pc are don't-care but must be stable.
- Reset mid-operation abandons any outstanding request. Responses arriving in IDLE are ignored.
- FSM states: IDLE, WAIT, DROP. At most one outstanding request.
- IDLE:
  - imem_req_valid = !flush && (count < DEPTH); imem_req_addr = pc.
  - On imem_req_valid && imem_req_ready: capture req_pc = pc, go WAIT, pc_enable=1 that cycle.
  - The PC advances by 1 at the same edge, so back-to-back requests are possible every other cycle.
- WAIT:
  - imem_req_valid=0.
  - On imem_resp_valid: write {req_pc, imem_resp_data} to FIFO, go IDLE.
  - A FIFO slot is guaranteed because requests are issued only when count < DEPTH.
- DROP:
  - imem_req_valid=0.
  - On imem_resp_valid: discard the data, go IDLE.
- pc_enable = (request handshake in IDLE) || flush. It is otherwise 0 (PC holds).
- flush (highest priority over everything except reset):
  - FIFO cleared: count=0, pointers=0. A same-cycle pop or push is cancelled.
  - No request is issued that cycle.
  - IDLE -> IDLE.
  - WAIT without resp_valid -> DROP.
  - WAIT with resp_valid the same cycle -> response discarded, IDLE.
  - DROP stays DROP unless resp_valid, then IDLE.
- Decode side:
  - inst_valid = (count != 0); inst_data/inst_pc = FIFO[rd_ptr].
  - Pop on inst_valid && inst_ready.
  - Simultaneous push and pop: count unchanged, both pointers advance.
- Pointers are log2(DEPTH) bits wide and wrap naturally. Count is log2(DEPTH)+1 bits, range 0..DEPTH.
- Latency: request accept -> earliest inst_valid is 2 cycles with a 1-cycle memory (resp cycle, then registered FIFO write).
- Full FIFO: no request issued, pc_enable=0, PC held until decode pops.
- imem_req_valid and imem_req_addr must not change while valid && !ready, unless flush is asserted (request withdrawn).

Test Plan:
- Reset held 2 cycles, then released with pc=0, ready=1, 1-cycle memory returning addr+0x100, inst_ready=1 -> inst_pc 0,1,2,3 with inst_data 0x100..0x103 in order; pc_enable pulses once per request; no duplicates or gaps.
- inst_ready=0 from the start -> after 2 instructions (pc 0,1) count=2, imem_req_valid=0, pc_enable=0, PC holds at 2. Raise inst_ready -> pc 0,1 drain, then pc 2 is fetched.
- flush while WAIT (request at pc=5 outstanding), PC loaded with 0x40 -> the pc=5 response is dropped, FIFO empty, next request addr=0x40, and the first decoded inst_pc=0x40.
- flush in the same cycle as imem_resp_valid in WAIT -> response discarded, state IDLE, count=0, the next cycle issues a request at the new PC.
- imem_req_ready low for 3 cycles with pc=7 -> imem_req_valid=1 and addr=7 stable all 3 cycles, pc_enable=0. Accepted on cycle 4 with pc_enable=1 exactly once.
- Reset asserted while WAIT with 1 FIFO entry -> next cycle inst_valid=0, state IDLE; a stale response arriving afterward is ignored.
